ppg_sample_capture: RTL and testbench

//  Reader side of the LED/ADC measurement interface. Follows the LED_RED/LED_IR phase

---
 rtl/ppg_pkg.sv | 25 ++
 rtl/ppg_peak_tracker.sv | 41 ++++
 rtl/ppg_sample_capture.sv | 174 +++++++++++++++++
 tb/tb_ppg_sample_capture.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// rtl/ppg_pkg.sv - shared encodings for the PPG sample capture block
package ppg_pkg;

    typedef logic [1:0] ppg_state_t;
    typedef logic [1:0] ppg_phase_t;

    localparam ppg_state_t ST_IDLE   = 2'd0;
    localparam ppg_state_t ST_SETTLE = 2'd1;
    localparam ppg_state_t ST_ACCUM  = 2'd2;
    localparam ppg_state_t ST_HOLD   = 2'd3;

    // Phase codes equal the raw {LED_RED, LED_IR} pattern
    localparam ppg_phase_t PH_DARK = 2'b00;
    localparam ppg_phase_t PH_IR   = 2'b01;
    localparam ppg_phase_t PH_RED  = 2'b10;
    localparam ppg_phase_t PH_ERR  = 2'b11;

    localparam logic CH_RED = 1'b0;
    localparam logic CH_IR  = 1'b1;

    function automatic logic is_lit(input ppg_phase_t ph);
        return (ph == PH_RED) || (ph == PH_IR);
    endfunction

endpackage

// File: rtl/ppg_peak_tracker.sv
// rtl/ppg_peak_tracker.sv - per-channel min/max tracker reporting max-min over a window
module ppg_peak_tracker #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         update,
    input  logic         clear,
    input  logic [W-1:0] sample,
    output logic [W-1:0] ac
);
    import ppg_pkg::*;

    logic [W-1:0] min_q;
    logic [W-1:0] max_q;
    logic [W-1:0] min_n;
    logic [W-1:0] max_n;

    // ac includes a sample arriving this cycle so the window close can use it directly
    always_comb begin
        min_n = min_q;
        max_n = max_q;
        if (update && (sample < min_q)) min_n = sample;
        if (update && (sample > max_q)) max_n = sample;
        ac = (max_n >= min_n) ? (max_n - min_n) : '0;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else if (clear) begin
            min_q <= '1;
            max_q <= '0;
        end else if (update) begin
            min_q <= min_n;
            max_q <= max_n;
        end
    end

endmodule

// File: rtl/ppg_sample_capture.sv
// rtl/ppg_sample_capture.sv - LED phase follower with settle, block average and AC window
module ppg_sample_capture #(
    parameter int ADC_W      = 8,
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 2,
    parameter int WIN_LEN    = 16
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             Enable,
    input  logic [ADC_W-1:0] ADC,
    input  logic             LED_RED,
    input  logic             LED_IR,
    output logic [ADC_W-1:0] RED_Avg,
    output logic [ADC_W-1:0] IR_Avg,
    output logic             Sample_valid,
    output logic             Sample_ch,
    output logic [ADC_W-1:0] RED_AC,
    output logic [ADC_W-1:0] IR_AC,
    output logic             AC_valid,
    output logic             Phase_error
);
    import ppg_pkg::*;

    localparam int ACC_W   = ADC_W + AVG_LOG2;
    localparam int N_AVG   = 1 << AVG_LOG2;
    localparam int CNT_MAX = (SETTLE_CYC > N_AVG) ? SETTLE_CYC : N_AVG;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);

    ppg_phase_t       phase_q, phase_prev_q;
    logic             err_q, err_d_q;
    ppg_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic             ch_q, ch_d;
    logic [WIN_W-1:0] win_cnt_q;
    logic             phase_chg, phase_lit;
    logic             publish, win_done;
    logic [ADC_W-1:0] avg_new, red_ac, ir_ac;

    // ERR is folded into DARK for sequencing; only the error pulse remembers it
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PH_DARK;
            phase_prev_q <= PH_DARK;
            err_q        <= 1'b0;
            err_d_q      <= 1'b0;
            Phase_error  <= 1'b0;
        end else begin
            phase_q      <= ({LED_RED, LED_IR} == PH_ERR) ? PH_DARK : {LED_RED, LED_IR};
            phase_prev_q <= phase_q;
            err_q        <= LED_RED & LED_IR;
            err_d_q      <= err_q;
            Phase_error  <= err_q & ~err_d_q;
        end
    end

    assign phase_chg = (phase_q != phase_prev_q);
    assign phase_lit = is_lit(phase_q);
    assign acc_sum   = acc_q + ACC_W'(ADC);
    assign avg_new   = acc_sum[ACC_W-1:AVG_LOG2];
    // The last ACCUM edge publishes even if a phase change arrives on it
    assign publish   = Enable && (state_q == ST_ACCUM) && (cnt_q == CNT_W'(N_AVG - 1));
    assign win_done  = publish && (ch_q == CH_IR) && (win_cnt_q == WIN_W'(WIN_LEN - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ch_d    = ch_q;
        if (!Enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (phase_chg) begin
            state_d = phase_lit ? ST_SETTLE : ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            ch_d    = (phase_q == PH_IR) ? CH_IR : CH_RED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (phase_lit) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                        acc_d   = '0;
                        ch_d    = (phase_q == PH_IR) ? CH_IR : CH_RED;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        state_d = ST_ACCUM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (cnt_q == CNT_W'(N_AVG - 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        acc_d = acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ch_q    <= CH_RED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ch_q    <= ch_d;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            RED_Avg      <= '0;
            IR_Avg       <= '0;
            Sample_valid <= 1'b0;
            Sample_ch    <= 1'b0;
            RED_AC       <= '0;
            IR_AC        <= '0;
            AC_valid     <= 1'b0;
            win_cnt_q    <= '0;
        end else begin
            Sample_valid <= publish;
            AC_valid     <= win_done;
            if (publish) begin
                Sample_ch <= ch_q;
                if (ch_q == CH_RED) RED_Avg <= avg_new;
                else                IR_Avg  <= avg_new;
            end
            if (win_done) begin
                RED_AC    <= red_ac;
                IR_AC     <= ir_ac;
                win_cnt_q <= '0;
            end else if (publish && (ch_q == CH_IR)) begin
                win_cnt_q <= win_cnt_q + WIN_W'(1);
            end
        end
    end

    ppg_peak_tracker #(.W(ADC_W)) u_red_peak (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .update (publish && (ch_q == CH_RED)),
        .clear  (win_done),
        .sample (avg_new),
        .ac     (red_ac)
    );

    ppg_peak_tracker #(.W(ADC_W)) u_ir_peak (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .update (publish && (ch_q == CH_IR)),
        .clear  (win_done),
        .sample (avg_new),
        .ac     (ir_ac)
    );

endmodule

// File: tb/tb_ppg_sample_capture.sv
// tb/tb_ppg_sample_capture.sv - scoreboard bench for ppg_sample_capture
module tb_ppg_sample_capture;
    import ppg_pkg::*;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       Enable = 1'b0;
    logic [7:0] ADC = 8'd0;
    logic       LED_RED = 1'b0;
    logic       LED_IR = 1'b0;
    logic [7:0] RED_Avg, IR_Avg, RED_AC, IR_AC;
    logic       Sample_valid, Sample_ch, AC_valid, Phase_error;

    ppg_sample_capture #(.ADC_W(8), .SETTLE_CYC(4), .AVG_LOG2(2), .WIN_LEN(16)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .Enable       (Enable),
        .ADC          (ADC),
        .LED_RED      (LED_RED),
        .LED_IR       (LED_IR),
        .RED_Avg      (RED_Avg),
        .IR_Avg       (IR_Avg),
        .Sample_valid (Sample_valid),
        .Sample_ch    (Sample_ch),
        .RED_AC       (RED_AC),
        .IR_AC        (IR_AC),
        .AC_valid     (AC_valid),
        .Phase_error  (Phase_error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct { bit ch; int avg; int at; } samp_t;
    typedef struct { int red; int ir; int at; } ac_t;
    samp_t sq[$];
    ac_t   aq[$];

    int m_min[2];
    int m_max[2];
    int m_avg[2];
    int m_win;
    int n_perr = 0;

    function automatic int ac_of(input int c);
        return (m_max[c] >= m_min[c]) ? (m_max[c] - m_min[c]) : 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_min[c] = 255;
            m_max[c] = 0;
            m_avg[c] = 0;
        end
        m_win = 0;
    endtask

    task automatic model_push(input bit ch, input int avg, input int at);
        samp_t s;
        ac_t a;
        s.ch = ch; s.avg = avg; s.at = at;
        sq.push_back(s);
        m_avg[ch] = avg;
        if (avg < m_min[ch]) m_min[ch] = avg;
        if (avg > m_max[ch]) m_max[ch] = avg;
        if (ch) begin
            m_win++;
            if (m_win == 16) begin
                a.red = ac_of(0); a.ir = ac_of(1); a.at = at;
                aq.push_back(a);
                for (int c = 0; c < 2; c++) begin
                    m_min[c] = 255;
                    m_max[c] = 0;
                end
                m_win = 0;
            end
        end
    endtask

    // Called at a negedge; n_acc<4 leaves the LEDs so the next call's switch lands on accumulate sample n_acc
    task automatic run_block(input bit ch, input int v0, input int v1, input int v2, input int v3,
                             input int n_acc);
        int v[4];
        int n_wait;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        LED_RED = ~ch;
        LED_IR  = ch;
        ADC     = 8'hEE;
        if (n_acc == 4) model_push(ch, (v0 + v1 + v2 + v3) >> 2, cyc + 1 + 9);
        repeat (6) @(negedge CLK);
        n_wait = (n_acc == 4) ? 4 : n_acc - 1;
        for (int i = 0; i < n_wait; i++) begin
            ADC = v[i][7:0];
            @(negedge CLK);
        end
    endtask

    always @(negedge CLK) begin
        samp_t s;
        ac_t a;
        if (Phase_error) n_perr++;
        if (Sample_valid) begin
            if (sq.size() == 0) check_eq("spurious_sample_valid", Sample_valid, 0);
            else begin
                s = sq.pop_front();
                check_eq("sample_ch", Sample_ch, s.ch);
                check_eq(s.ch ? "ir_avg" : "red_avg", s.ch ? IR_Avg : RED_Avg, s.avg);
                check_eq("sample_latency", cyc, s.at);
            end
        end
        if (AC_valid) begin
            if (aq.size() == 0) check_eq("spurious_ac_valid", AC_valid, 0);
            else begin
                a = aq.pop_front();
                check_eq("red_ac", RED_AC, a.red);
                check_eq("ir_ac", IR_AC, a.ir);
                check_eq("ac_cycle", cyc, a.at);
            end
        end
    end

    initial begin
        int p0;
        model_reset();
        repeat (3) @(negedge CLK);
        check_eq("rst_avg_ac", {RED_Avg, IR_Avg, RED_AC, IR_AC}, 0);
        check_eq("rst_pulses", {Sample_valid, Sample_ch, AC_valid, Phase_error}, 0);
        check_eq("rst_state", dut.state_q, ST_IDLE);
        rst_n  = 1'b1;
        Enable = 1'b1;
        @(negedge CLK);

        // basic red block, then IR block
        run_block(CH_RED, 100, 101, 102, 103, 4);
        run_block(CH_IR, 200, 200, 200, 200, 4);
        check_eq("red_hold_after_ir", RED_Avg, 101);

        // red aborted after two accumulate samples by a switch to IR
        run_block(CH_RED, 10, 20, 0, 0, 2);
        run_block(CH_IR, 50, 60, 70, 80, 4);
        check_eq("red_hold_after_abort", RED_Avg, 101);

        // both LEDs high for one cycle mid-accumulate, then dark
        run_block(CH_RED, 1, 2, 0, 0, 2);
        p0 = n_perr;
        LED_RED = 1'b1; LED_IR = 1'b1;
        @(negedge CLK);
        LED_RED = 1'b0; LED_IR = 1'b0;
        repeat (12) @(negedge CLK);
        check_eq("phase_error_pulses", n_perr, p0 + 1);
        check_eq("idle_while_dark", dut.state_q, ST_IDLE);
        check_eq("red_hold_after_err", RED_Avg, 101);

        // Enable dropped during settle
        LED_RED = 1'b1;
        repeat (3) @(negedge CLK);
        Enable = 1'b0;
        repeat (4) @(negedge CLK);
        check_eq("idle_on_disable", dut.state_q, ST_IDLE);
        check_eq("avg_hold_disable", {RED_Avg, IR_Avg}, {8'd101, 8'd65});
        LED_RED = 1'b0;
        @(negedge CLK);
        Enable = 1'b1;
        repeat (3) @(negedge CLK);

        // reset mid-accumulate
        run_block(CH_RED, 5, 6, 0, 0, 2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_avg_ac", {RED_Avg, IR_Avg, RED_AC, IR_AC}, 0);
        check_eq("midrst_pulses", {Sample_valid, Sample_ch, AC_valid, Phase_error}, 0);
        check_eq("midrst_state", dut.state_q, ST_IDLE);
        @(negedge CLK);
        LED_RED = 1'b0; LED_IR = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);

        // first AC window: red alternates 90/110, IR constant
        for (int i = 0; i < 16; i++) begin
            if (i % 2) run_block(CH_RED, 110, 110, 110, 110, 4);
            else       run_block(CH_RED, 90, 90, 90, 90, 4);
            run_block(CH_IR, 150, 150, 150, 150, 4);
        end
        // second window must not see the first window's extremes
        for (int i = 0; i < 16; i++) begin
            run_block(CH_RED, 50, 50, 50, 50, 4);
            if (i % 2) run_block(CH_IR, 29, 30, 31, 31, 4);
            else       run_block(CH_IR, 10, 11, 12, 13, 4);
        end
        repeat (4) @(negedge CLK);
        check_eq("sample_queue_drained", sq.size(), 0);
        check_eq("ac_queue_drained", aq.size(), 0);
        check_eq("final_avgs", {RED_Avg, IR_Avg}, {8'd50, 8'd30});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
